popcount_arbiter: RTL and testbench
===================================

POPCOUNT_ARBITER -- requirements
Module: popcount_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters; fixed at 4 for this revision.
REQ-002 SHALL have parameter DW, default 32, data word width; fixed at 32 for this revision.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-requester request, level-sensitive.
REQ-006 SHALL have port data_i  input  128  flattened words; requester k uses bits [32k+31:32k].
REQ-007 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-008 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have port res_count  output  6  number of ones in the captured word, 0..32.
REQ-012 SHALL have port res_nonzero  output  1  high when res_count != 0.
REQ-013 SHALL have port res_ack  input  1  consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-015 SHALL, in IDLE at an edge with any req bit high:
- select the winner round-robin, searching from (ptr+1) mod 4 upward;
- capture the winner's 32-bit word into a shift register;
- clear the accumulator and the 2-bit chunk counter;
- set gnt to the winner's one-hot bit and enter COUNT.
REQ-016 SHALL hold gnt high for exactly one cycle per grant; gnt SHALL be 0 in all other cycles.
REQ-017 SHALL, in IDLE with req == 0, stay in IDLE with all outputs at 0.
REQ-018 SHALL, at each COUNT edge:
- add the popcount of the shift register's low 8 bits to a 6-bit accumulator;
- shift the register right by 8 and increment the chunk counter;
- enter DONE after the 4th chunk.
REQ-019 SHALL assert res_valid at the 4th edge after the capture edge (fixed latency 4).
REQ-020 SHALL drive res_id, res_count and res_nonzero only while res_valid is high; all three SHALL be 0 otherwise.
REQ-021 SHALL, in DONE, hold res_valid, res_id, res_count and res_nonzero stable until res_ack is sampled high.
REQ-022 SHALL, at the edge res_ack is sampled high in DONE:
- update ptr to the winner index;
- clear res_valid and enter IDLE;
- complete the next grant no earlier than the following edge (minimum 6-cycle period per word).
REQ-023 SHALL ignore res_ack in IDLE and COUNT.
REQ-024 SHALL ignore changes to req and data_i after the capture edge until the FSM returns to IDLE.
REQ-025 SHALL not serve a request that is deasserted before its grant; requesters must hold req and data_i stable until gnt is observed.
REQ-026 SHALL give the 32-bit word of all ones res_count = 32 (no overflow of the 6-bit accumulator), and the zero word res_count = 0 with res_nonzero = 0.
REQ-027 SHALL never grant the same requester twice in a row while another requester is continuously requesting.

Reset
REQ-028 SHALL, on rst low, immediately and asynchronously set:
- FSM to IDLE and ptr to 3, so requester 0 is first priority;
- gnt = 0, busy = 0, res_valid = 0, res_id = 0, res_count = 0, res_nonzero = 0;
- accumulator, chunk counter and shift register to 0.
REQ-029 SHALL abandon any in-flight operation on reset assertion mid-COUNT or mid-DONE, and SHALL NOT produce a result for it after reset release.
REQ-030 SHALL evaluate requests no earlier than the first posedge clk with rst high.

Verification
REQ-031 SHALL cover a single request: req=0001, data0=32'h0000_00FF -> gnt=0001 for 1 cycle; res_valid 4 cycles later; res_id=0, res_count=8, res_nonzero=1.
REQ-032 SHALL cover the boundary words: data=32'hFFFF_FFFF -> res_count=32; data=32'h0 -> res_count=0, res_nonzero=0; data=32'h8000_0001 -> res_count=2.
REQ-033 SHALL cover round-robin order: req=1111 held, res_ack tied high -> grants in order 0,1,2,3,0; consecutive gnt pulses 6 cycles apart.
REQ-034 SHALL cover result hold: res_ack low for 10 cycles after res_valid -> res_valid and res_count stable all 10 cycles; busy=1; gnt=0000.
REQ-035 SHALL cover reset mid-COUNT: rst low at the 2nd COUNT cycle -> all outputs 0 immediately; after release with req=0010 -> requester 1 is granted and the fresh result is correct.
REQ-036 SHALL cover data and req change after capture: data0 changed and req0 dropped after gnt -> result reflects the captured word; res_id=0.

Source files
------------

// File: rtl/popcount_arbiter_if.sv
// Request/result bundle between requesters and the popcount arbiter.
// The requester side is the master; the arbiter is the slave.
interface popcount_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32
);
   logic [NREQ-1:0]         req;
   logic [NREQ*DW-1:0]      data_i;
   logic [NREQ-1:0]         gnt;
   logic                    busy;
   logic                    res_valid;
   logic [$clog2(NREQ)-1:0] res_id;
   logic [$clog2(DW):0]     res_count;
   logic                    res_nonzero;
   logic                    res_ack;

   modport master (
      output req, data_i, res_ack,
      input  gnt, busy, res_valid, res_id, res_count, res_nonzero
   );

   modport slave (
      input  req, data_i, res_ack,
      output gnt, busy, res_valid, res_id, res_count, res_nonzero
   );
endinterface

// File: rtl/popcount_arbiter.sv
// Round-robin arbiter that popcounts the winner's word 8 bits per cycle; grant to res_valid is 4 cycles.
// The result is held until res_ack; no new grant is issued until the FSM is back in IDLE.
module popcount_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32
) (
   input  logic              clk,
   input  logic              rst,
   popcount_arbiter_if.slave bus
);
   localparam int IW     = $clog2(NREQ);
   localparam int CW     = $clog2(DW) + 1;
   localparam int NCHUNK = DW / 8;
   localparam int CHW    = $clog2(NCHUNK);
   localparam logic [CHW-1:0] LAST_CHUNK = CHW'(NCHUNK - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_id;
   logic [IW-1:0]   pick_id;
   logic [IW-1:0]   cand;
   logic            pick_vld;
   logic [DW-1:0]   pick_dat;
   logic [NREQ-1:0] gnt_q;
   logic [DW-1:0]   sreg;
   logic [CW-1:0]   acc;
   logic [CHW-1:0]  chunk;

   function automatic logic [3:0] pop8(input logic [7:0] b);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + {3'b000, b[i]};
      return s;
   endfunction

   // Search starts one past the last served requester and wraps back to it.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      cand     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = ptr + IW'(i);
         if (!pick_vld && bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
      pick_dat = bus.data_i[32'(pick_id) * DW +: DW];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ptr    <= IW'(NREQ - 1);
         win_id <= '0;
         gnt_q  <= '0;
         sreg   <= '0;
         acc    <= '0;
         chunk  <= '0;
      end else begin
         gnt_q <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  sreg   <= pick_dat;
                  acc    <= '0;
                  chunk  <= '0;
                  win_id <= pick_id;
                  gnt_q  <= NREQ'(1) << pick_id;
                  state  <= COUNT;
               end
            end
            COUNT: begin
               acc   <= acc + CW'(pop8(sreg[7:0]));
               sreg  <= sreg >> 8;
               chunk <= chunk + CHW'(1);
               if (chunk == LAST_CHUNK) state <= DONE;
            end
            DONE: begin
               if (bus.res_ack) begin
                  ptr   <= win_id;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result fields are masked outside DONE so stale state never leaks out.
   assign bus.gnt         = gnt_q;
   assign bus.busy        = (state != IDLE);
   assign bus.res_valid   = (state == DONE);
   assign bus.res_id      = (state == DONE) ? win_id : '0;
   assign bus.res_count   = (state == DONE) ? acc : '0;
   assign bus.res_nonzero = (state == DONE) && (acc != '0);
endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter: reset, latency, boundary words, round robin, hold and mid-flight reset.
module tb_popcount_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   int          bnd_id  [4] = '{2, 3, 1, 0};
   logic [31:0] bnd_w   [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'hA5A5_A5A5};
   int          bnd_cnt [4] = '{32, 0, 2, 16};
   int          rr_exp  [5] = '{0, 1, 2, 3, 0};

   popcount_arbiter_if #(.NREQ(4), .DW(32)) bus ();

   popcount_arbiter #(.NREQ(4), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one single-requester transaction and reports what was observed.
   task automatic do_word(input int idx, input logic [31:0] w, output logic [3:0] g,
                          output int lat, output logic [1:0] id, output logic [5:0] cnt,
                          output logic nz);
      bus.req = 4'(1 << idx);
      bus.data_i[idx*32 +: 32] = w;
      step();
      g = bus.gnt;
      bus.req = '0;
      lat = 0;
      while (bus.res_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      id  = bus.res_id;
      cnt = bus.res_count;
      nz  = bus.res_nonzero;
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req = 4'b1111;
      bus.data_i = '1;
      bus.res_ack = 1'b0;
      #2;
      n_cmp++;
      if ({bus.gnt, bus.busy, bus.res_valid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000000", {bus.gnt, bus.busy, bus.res_valid});
      end
      n_cmp++;
      if ({bus.res_id, bus.res_count, bus.res_nonzero} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_result: got %b want 0", {bus.res_id, bus.res_count, bus.res_nonzero});
      end
      step();
      step();
      n_cmp++;
      if ({bus.gnt, bus.busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_held_req: got %b want 00000", {bus.gnt, bus.busy});
      end
      bus.req = '0;
      bus.data_i = '0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({bus.gnt, bus.busy, bus.res_valid, bus.res_count} !== 12'b0) begin
            n_fail++;
            $display("FAIL idle_no_req cycle %0d: got %b want 0", i,
                     {bus.gnt, bus.busy, bus.res_valid, bus.res_count});
         end
      end
   endtask

   task automatic test_single();
      bus.req = 4'b0001;
      bus.data_i[31:0] = 32'h0000_00FF;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: got gnt=%b busy=%b want gnt=0001 busy=1", bus.gnt, bus.busy);
      end
      bus.req = '0;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt);
      end
      step();
      step();
      n_cmp++;
      if (bus.res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early_valid: got %b want 0", bus.res_valid);
      end
      step();
      n_cmp++;
      if ({bus.res_valid, bus.res_id, bus.res_count, bus.res_nonzero} !== {1'b1, 2'd0, 6'd8, 1'b1}) begin
         n_fail++;
         $display("FAIL single_result: got v=%b id=%0d cnt=%0d nz=%b want v=1 id=0 cnt=8 nz=1",
                  bus.res_valid, bus.res_id, bus.res_count, bus.res_nonzero);
      end
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      n_cmp++;
      if ({bus.res_valid, bus.busy, bus.res_count} !== 8'b0) begin
         n_fail++;
         $display("FAIL single_ack: got v=%b busy=%b cnt=%0d want all 0",
                  bus.res_valid, bus.busy, bus.res_count);
      end
   endtask

   task automatic test_boundary();
      logic [3:0] g;
      int         lat;
      logic [1:0] id;
      logic [5:0] cnt;
      logic       nz;
      for (int i = 0; i < 4; i++) begin
         do_word(bnd_id[i], bnd_w[i], g, lat, id, cnt, nz);
         n_cmp++;
         if (g !== 4'(1 << bnd_id[i])) begin
            n_fail++;
            $display("FAIL boundary_gnt[%0d]: got %b want %b", i, g, 4'(1 << bnd_id[i]));
         end
         n_cmp++;
         if (lat != 4) begin
            n_fail++;
            $display("FAIL boundary_latency[%0d]: got %0d want 4", i, lat);
         end
         n_cmp++;
         if (id !== 2'(bnd_id[i])) begin
            n_fail++;
            $display("FAIL boundary_id[%0d]: got %0d want %0d", i, id, bnd_id[i]);
         end
         n_cmp++;
         if (cnt !== 6'(bnd_cnt[i])) begin
            n_fail++;
            $display("FAIL boundary_count[%0d]: got %0d want %0d", i, cnt, bnd_cnt[i]);
         end
         n_cmp++;
         if (nz !== (bnd_cnt[i] != 0)) begin
            n_fail++;
            $display("FAIL boundary_nonzero[%0d]: got %b want %b", i, nz, bnd_cnt[i] != 0);
         end
      end
   endtask

   task automatic test_round_robin();
      int gid  [5] = '{-1, -1, -1, -1, -1};
      int gcyc [5] = '{-100, -100, -100, -100, -100};
      int ng  = 0;
      int cyc = 0;
      int t   = 0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus.data_i = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
      bus.req = 4'b1111;
      bus.res_ack = 1'b1;
      while (ng < 5 && cyc < 60) begin
         step();
         cyc++;
         if (bus.gnt != 4'b0000) begin
            for (int k = 0; k < 4; k++) if (bus.gnt[k]) gid[ng] = k;
            gcyc[ng] = cyc;
            ng++;
         end
      end
      bus.req = '0;
      while (bus.busy !== 1'b0 && t < 20) begin
         step();
         t++;
      end
      bus.res_ack = 1'b0;
      n_cmp++;
      if (ng != 5 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_grant_count: got %0d grants busy=%b want 5 grants busy=0", ng, bus.busy);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (gid[i] != rr_exp[i]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, gid[i], rr_exp[i]);
         end
      end
      for (int i = 1; i < 5; i++) begin
         n_cmp++;
         if (gcyc[i] - gcyc[i-1] != 6) begin
            n_fail++;
            $display("FAIL rr_spacing[%0d]: got %0d want 6", i, gcyc[i] - gcyc[i-1]);
         end
      end
   endtask

   task automatic test_hold();
      bus.req = 4'b0100;
      bus.data_i[95:64] = 32'h0F0F_0000;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL hold_grant: got %b want 0100", bus.gnt);
      end
      bus.req = '0;
      bus.res_ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.res_ack = 1'b0;
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.res_count !== 6'd8) begin
         n_fail++;
         $display("FAIL hold_ack_in_count: got v=%b cnt=%0d want v=1 cnt=8", bus.res_valid, bus.res_count);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if ({bus.res_valid, bus.busy, bus.gnt, bus.res_id, bus.res_count, bus.res_nonzero}
             !== {1'b1, 1'b1, 4'b0000, 2'd2, 6'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_stable cycle %0d: got v=%b busy=%b gnt=%b id=%0d cnt=%0d want v=1 busy=1 gnt=0000 id=2 cnt=8",
                     i, bus.res_valid, bus.busy, bus.gnt, bus.res_id, bus.res_count);
         end
      end
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      n_cmp++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: got v=%b busy=%b want 0 0", bus.res_valid, bus.busy);
      end
   endtask

   task automatic test_reset_mid_count();
      int lat = 0;
      bus.req = 4'b0001;
      bus.data_i[31:0] = 32'hFFFF_FFFF;
      step();
      bus.req = '0;
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({bus.gnt, bus.busy, bus.res_valid, bus.res_count} !== 12'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %b want 0", {bus.gnt, bus.busy, bus.res_valid, bus.res_count});
      end
      bus.req = 4'b0010;
      bus.data_i[63:32] = 32'h0000_0703;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_no_grant_in_reset: got gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy);
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL midreset_regrant: got %b want 0010", bus.gnt);
      end
      bus.req = '0;
      while (bus.res_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      n_cmp++;
      if (lat != 4 || bus.res_id !== 2'd1 || bus.res_count !== 6'd5 || bus.res_nonzero !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_result: got lat=%0d id=%0d cnt=%0d nz=%b want lat=4 id=1 cnt=5 nz=1",
                  lat, bus.res_id, bus.res_count, bus.res_nonzero);
      end
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
   endtask

   task automatic test_change_after_capture();
      int lat = 0;
      bus.req = 4'b0001;
      bus.data_i[31:0] = 32'h0000_0003;
      step();
      n_cmp++;
      if (bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL change_grant: got %b want 0001", bus.gnt);
      end
      bus.data_i[31:0] = 32'hFFFF_FFFF;
      bus.req = '0;
      while (bus.res_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      n_cmp++;
      if (lat != 4 || bus.res_id !== 2'd0 || bus.res_count !== 6'd2 || bus.res_nonzero !== 1'b1) begin
         n_fail++;
         $display("FAIL change_result: got lat=%0d id=%0d cnt=%0d nz=%b want lat=4 id=0 cnt=2 nz=1",
                  lat, bus.res_id, bus.res_count, bus.res_nonzero);
      end
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_boundary();
      test_round_robin();
      test_hold();
      test_reset_mid_count();
      test_change_after_capture();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
